// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int              DEF_PC_W        = 8;
    localparam int              DEF_STACK_DEPTH = 4;
    localparam logic [7:0]      DEF_RESET_VEC   = 8'h00;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO: only the occupancy counter is reset, the
// entries are plain storage.
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [W-1:0]    i_push_data,
    output logic [W-1:0]    o_top,
    output logic [SP_W-1:0] o_sp,
    output logic            o_full,
    output logic            o_empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

    assign o_sp    = r_sp;
    assign o_full  = (r_sp == SP_W'(DEPTH));
    assign o_empty = (r_sp == '0);
    assign o_top   = r_mem[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_sp <= '0;
        end else if (i_clear) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks fetch, jump, call, return, stall or halt
// each cycle and drives the instruction ROM address.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter int              STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(DEF_RESET_VEC),
    parameter int              SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic [SP_W-1:0] sp,
    output logic            stack_err
);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic            r_err, w_err_nxt;
    logic            w_push, w_pop, w_clear;
    logic [PC_W-1:0] w_top;
    logic            w_full, w_empty;

    return_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_W)
    ) u_stack (
        .clk         (CLK),
        .rst         (reset),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (r_pc + PC_W'(1)),
        .o_top       (w_top),
        .o_sp        (sp),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_VEC;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = RESET_VEC;
                    w_err_nxt   = 1'b0;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                // Fixed priority halt > ret > call > branch > increment; stall freezes all.
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = HALT;
                    end else if (ret) begin
                        if (w_empty) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HALT;
                        end else begin
                            w_pc_nxt = w_top;
                            w_pop    = 1'b1;
                        end
                    end else if (call) begin
                        if (w_full) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HALT;
                        end else begin
                            w_pc_nxt = target;
                            w_push   = 1'b1;
                        end
                    end else if (branch) begin
                        w_pc_nxt = target;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign pc          = r_pc;
    assign stack_err   = r_err;
    assign fetch_valid = (r_state == RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed scenarios plus random control traffic,
// all compared against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int DEPTH  = 4;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stall = 1'b0, branch = 1'b0;
    logic       call = 1'b0, ret = 1'b0, halt = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic       fetch_valid;
    logic [2:0] sp;
    logic       stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: plain integers and a queue for the return stack.
    int m_state;
    int m_pc;
    int m_err;
    int m_q[$];

    pc_sequencer dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .halt        (halt),
        .target      (target),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .sp          (sp),
        .stack_err   (stack_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_err   = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        case (m_state)
            M_IDLE, M_HALT: begin
                if (start) begin
                    m_state = M_RUN;
                    m_pc    = 0;
                    m_err   = 0;
                    m_q.delete();
                end
            end
            default: begin
                if (!stall) begin
                    if (halt) begin
                        m_state = M_HALT;
                    end else if (ret) begin
                        if (m_q.size() == 0) begin
                            m_err = 1; m_state = M_HALT;
                        end else begin
                            m_pc = m_q.pop_back();
                        end
                    end else if (call) begin
                        if (m_q.size() == DEPTH) begin
                            m_err = 1; m_state = M_HALT;
                        end else begin
                            m_q.push_back((m_pc + 1) % 256);
                            m_pc = int'(target);
                        end
                    end else if (branch) begin
                        m_pc = int'(target);
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                    end
                end
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc"},  int'(pc),        m_pc);
        check({tag, ".sp"},  int'(sp),        m_q.size());
        check({tag, ".err"}, int'(stack_err), m_err);
    endtask

    // One clock: drive controls, check combinational fetch_valid, step the
    // model across the edge, then check the registered outputs.
    task automatic cycle(input string tag, input bit st, input bit sl, input bit br,
                         input bit ca, input bit re, input bit ha, input logic [7:0] tg);
        start = st; stall = sl; branch = br; call = ca; ret = re; halt = ha; target = tg;
        #1;
        check({tag, ".fv"}, int'(fetch_valid), int'(m_state == M_RUN && !sl));
        model_edge();
        @(posedge CLK);
        #1;
        check_regs(tag);
    endtask

    task automatic idle_cycle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        model_reset();
        #23 reset = 1'b0;
        @(posedge CLK); #1;
        check("reset.fv", int'(fetch_valid), 0);
        check_regs("reset");

        // Sequential fetch
        cycle("start", 1, 0, 0, 0, 0, 0, 8'h00);
        check("seq.pc0", int'(pc), 0);
        for (int i = 0; i < 5; i++) idle_cycle("seq");
        check("seq.pc5", int'(pc), 5);

        // Call / return / wrap
        cycle("call40", 0, 0, 0, 1, 0, 0, 8'h40);
        check("call40.pc", int'(pc), 8'h40);
        check("call40.sp", int'(sp), 1);
        idle_cycle("inc1");
        idle_cycle("inc2");
        cycle("ret", 0, 0, 0, 0, 1, 0, 8'h00);
        check("ret.pc", int'(pc), 6);
        check("ret.sp", int'(sp), 0);
        cycle("brFF", 0, 0, 1, 0, 0, 0, 8'hFF);
        check("brFF.pc", int'(pc), 8'hFF);
        idle_cycle("wrap");
        check("wrap.pc", int'(pc), 0);

        // Overflow
        for (int i = 1; i <= 5; i++) begin
            cycle("nest", 0, 0, 0, 1, 0, 0, 8'(i * 10));
            if (i == 4) begin
                check("ovf.sp4", int'(sp), 4);
                check("ovf.pc40", int'(pc), 40);
            end
        end
        check("ovf.err", int'(stack_err), 1);
        check("ovf.pc", int'(pc), 40);
        idle_cycle("ovf.halt");
        check("ovf.fv", int'(fetch_valid), 0);
        cycle("restart", 1, 0, 0, 0, 0, 0, 8'h00);
        check("restart.pc", int'(pc), 0);
        check("restart.sp", int'(sp), 0);
        check("restart.err", int'(stack_err), 0);

        // Underflow
        for (int i = 0; i < 3; i++) idle_cycle("udf.inc");
        cycle("udf.ret", 0, 0, 0, 0, 1, 0, 8'h00);
        check("udf.err", int'(stack_err), 1);
        check("udf.pc", int'(pc), 3);
        idle_cycle("udf.halt");
        check("udf.fv", int'(fetch_valid), 0);

        // Priority: at sp=1 with top=9, ret wins over call and branch
        cycle("prio.start", 1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) idle_cycle("prio.inc");
        cycle("prio.call", 0, 0, 0, 1, 0, 0, 8'h20);
        cycle("prio.all", 0, 0, 1, 1, 1, 0, 8'h77);
        check("prio.pc", int'(pc), 9);
        check("prio.sp", int'(sp), 0);

        // Stall masks halt; release with halt still high halts
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 0, 1, 0, 0, 0, 1, 8'h00);
            check("stall.pc", int'(pc), 9);
        end
        cycle("unstall", 0, 0, 0, 0, 0, 1, 8'h00);
        idle_cycle("unstall.halt");
        check("unstall.fv", int'(fetch_valid), 0);

        // Async reset mid-operation with sp=2, pc=0x40
        cycle("ar.start", 1, 0, 0, 0, 0, 0, 8'h00);
        cycle("ar.call1", 0, 0, 0, 1, 0, 0, 8'h40);
        cycle("ar.call2", 0, 0, 0, 1, 0, 0, 8'h40);
        check("ar.pre.sp", int'(sp), 2);
        #2 reset = 1'b1;
        #1;
        check("ar.pc", int'(pc), 0);
        check("ar.sp", int'(sp), 0);
        check("ar.fv", int'(fetch_valid), 0);
        model_reset();
        #10 reset = 1'b0;
        @(posedge CLK); #1;
        check_regs("ar.post");

        // Random control traffic
        for (int n = 0; n < 600; n++) begin
            cycle("rnd",
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7)  == 0,
                  $urandom_range(0, 5)  == 0,
                  $urandom_range(0, 4)  == 0,
                  $urandom_range(0, 4)  == 0,
                  $urandom_range(0, 39) == 0,
                  8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the 256-entry, 24-bit instruction ROM. It owns the PC register and drives the ROM read address. It decides each cycle between sequential fetch, jump, subroutine call and return (via a small hardware return-address stack), stall and halt. Control inputs come from the instruction decoder; `pc` feeds the ROM address directly.

Parameters:
PC_W, 8, PC and jump-target width; ROM depth is 2**PC_W.
STACK_DEPTH, 4, number of return-address stack entries.
RESET_VEC, 8'h00, PC loaded at reset and on every start.

Ports:
CLK  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin execution from RESET_VEC; honoured in IDLE and HALT only.
stall  in  1  freeze the PC and stack this cycle.
branch  in  1  unconditional jump to target.
call  in  1  push return address, jump to target.
ret  in  1  pop return address into pc.
halt  in  1  stop fetching.
target  in  PC_W  jump/call destination.
pc  out  PC_W  ROM read address.
fetch_valid  out  1  high when instr at pc is to be consumed.
sp  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
stack_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (async, any time including mid-call): state=IDLE, pc=RESET_VEC, sp=0, stack_err=0, fetch_valid=0. Stack contents don't care.
- States: IDLE, RUN, HALT.
- fetch_valid = (state==RUN) && !stall. It is combinational from the registered state and stall.
- IDLE:
  - start -> RUN next edge; pc=RESET_VEC.
  - Other inputs ignored.
- RUN, stall=1:
  - pc, sp, stack and state hold.
  - All other control inputs ignored, including halt.
- RUN, stall=0: one action per edge, fixed priority halt > ret > call > branch > increment.
  - halt: state->HALT; pc holds.
  - ret:
    - sp>0: pc<=stack[sp-1], sp<=sp-1.
    - sp==0 (underflow): stack_err<=1, state->HALT, pc and sp hold.
  - call:
    - sp<STACK_DEPTH: stack[sp]<=pc+1 (mod 2**PC_W), sp<=sp+1, pc<=target.
    - sp==STACK_DEPTH (overflow): stack_err<=1, state->HALT, pc and sp hold.
  - branch: pc<=target.
  - none asserted: pc<=pc+1, wrapping 2**PC_W-1 -> 0 with no flag.
- HALT:
  - fetch_valid=0; pc holds.
  - start -> RUN with pc=RESET_VEC, sp=0, stack_err=0.
- start while in RUN is ignored.
- Latency: a control input sampled at edge N sets the new pc after edge N. The ROM instruction for that pc is visible combinationally in the same cycle.
- No combinational path from any input to pc or sp.

Decomposition:
- Package pc_seq_pkg:
  - state enum {IDLE, RUN, HALT}.
  - Default PC_W and RESET_VEC localparams.
- One sub-module, return_stack:
  - LIFO with push, pop, push_data, top, sp, full and empty.
  - Async reset of sp only.
  - push and pop are never asserted together by pc_sequencer.

Test Plan:
- Sequential fetch: reset pulse, start for 1 cycle -> pc sequence 0,1,2,3; fetch_valid=1 from the first RUN cycle; sp=0.
- Call/return and wrap-around:
  - At pc=5, call with target=8'h40 -> pc=8'h40, sp=1.
  - Two increments, then ret -> pc=6, sp=0.
  - Branch target=8'hFF then no control -> pc=8'hFF, then 8'h00.
- Overflow:
  - Five nested calls, targets 10,20,30,40,50, with STACK_DEPTH=4.
  - Response -> sp=4, pc=40 after the 4th call; 5th call gives stack_err=1, state HALT, pc=40, fetch_valid=0.
  - start -> pc=0, sp=0, stack_err=0.
- Underflow: ret at sp=0, pc=3 -> stack_err=1, HALT, pc stays 3.
- Priority and stall:
  - branch+call+ret together at sp=1 (top=9) -> pc=9, sp=0.
  - stall=1 with halt=1 for 3 cycles -> pc frozen, fetch_valid=0, state remains RUN.
  - stall released with halt still high -> HALT.
- Async reset mid-operation: assert reset between edges while sp=2, pc=8'h40 -> pc=0, sp=0, fetch_valid=0 immediately, without waiting for CLK.
